// File: rtl/alu_seq_if.sv
// ALU <-> control/accumulator bundle: control word, operands, result and status.
// Latency: none; pure signal grouping.
// Backpressure: none; busy tells the control unit a multi-cycle op is running.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic [31:0]      control_signal;
  logic [WIDTH-1:0] from_ACC;
  logic [WIDTH-1:0] from_BR;
  logic [WIDTH-1:0] to_ACC;
  logic [WIDTH-1:0] to_MR;
  logic             busy;
  logic             done;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  // Control unit / accumulator side
  modport master (
    output control_signal, from_ACC, from_BR,
    input  to_ACC, to_MR, busy, done, carry, zero, div_by_zero
  );

  // ALU side
  modport slave (
    input  control_signal, from_ACC, from_BR,
    output to_ACC, to_MR, busy, done, carry, zero, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// 16-bit ALU: combinational single-cycle ops plus shift-add MPY / restoring DIV engine.
// Latency: single-cycle ops 0 cycles; MPY/DIV done 17 cycles after start (DIV by 0: 1 cycle).
// Backpressure: start bits are ignored while busy or done; single-cycle ops always accepted.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  // One-hot op bit positions in the microcode control word
  localparam int B_ADD  = 9;
  localparam int B_SUB  = 11;
  localparam int B_AND  = 12;
  localparam int B_OR   = 14;
  localparam int B_NOT  = 15;
  localparam int B_SHR  = 16;
  localparam int B_SHL  = 17;
  localparam int B_PASS = 18;
  localparam int B_MPY  = 19;
  localparam int B_DIV  = 20;

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   result_q;     // low product / quotient
  logic [WIDTH-1:0]   mr_q;         // high product / remainder
  logic               carry_q, carry_d;
  logic               dbz_q;
  logic [WIDTH-1:0]   a_q;          // latched multiplicand
  logic [WIDTH-1:0]   b_q;          // latched divisor
  logic [2*WIDTH-1:0] prod_q;       // {hi, lo}: MPY {partial, multiplier}, DIV {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q;

  logic [31:0]      ctl;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   add_sum;

  logic start_mpy, start_div, div_b_zero, cnt_last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_trial;
  logic [2*WIDTH-1:0] div_next;

  // Control bits this ALU does not decode
  logic unused_ctl;

  assign ctl = bus.control_signal;
  assign opa = bus.from_ACC;
  assign opb = bus.from_BR;

  assign unused_ctl = ^{ctl[31:21], ctl[13], ctl[10], ctl[8:0]};

  // MPY wins when both start bits are high
  assign start_mpy  = ctl[B_MPY];
  assign start_div  = ctl[B_DIV] & ~ctl[B_MPY];
  assign div_b_zero = (opb == '0);
  assign cnt_last   = (cnt_q == CNT_W'(ITER - 1));

  assign add_sum = {1'b0, opa} + {1'b0, opb};

  // Priority decode of single-cycle ops; carry follows only the winning op
  always_comb begin
    alu_res = result_q;
    carry_d = carry_q;
    if (ctl[B_PASS]) begin
      alu_res = result_q;
    end else if (ctl[B_ADD]) begin
      alu_res = add_sum[WIDTH-1:0];
      carry_d = add_sum[WIDTH];
    end else if (ctl[B_SUB]) begin
      alu_res = opa - opb;
      carry_d = (opa >= opb);
    end else if (ctl[B_AND]) begin
      alu_res = opa & opb;
    end else if (ctl[B_OR]) begin
      alu_res = opa | opb;
    end else if (ctl[B_NOT]) begin
      alu_res = ~opa;
    end else if (ctl[B_SHR]) begin
      alu_res = {1'b0, opa[WIDTH-1:1]};
      carry_d = opa[0];
    end else if (ctl[B_SHL]) begin
      alu_res = {opa[WIDTH-2:0], 1'b0};
      carry_d = opa[WIDTH-1];
    end
  end

  // One shift-add multiply step and one restoring divide step on prod_q
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    rem_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, b_q};
    // Negative trial (top bit set) means the divisor did not fit: restore
    if (!rem_trial[WIDTH]) begin
      div_next = {rem_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start bits only matter in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_mpy) begin
          state_d = S_MUL;
        end else if (start_div) begin
          state_d = div_b_zero ? S_DONE : S_DIV;
        end
      end
      S_MUL:   if (cnt_last) state_d = S_DONE;
      S_DIV:   if (cnt_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath, results and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      mr_q     <= '0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      carry_q <= carry_d;
      case (state_q)
        S_IDLE: begin
          if (start_mpy) begin
            a_q    <= opa;
            b_q    <= opb;
            prod_q <= {{WIDTH{1'b0}}, opb};
            cnt_q  <= '0;
            dbz_q  <= 1'b0;
          end else if (start_div) begin
            a_q   <= opa;
            b_q   <= opb;
            cnt_q <= '0;
            dbz_q <= div_b_zero;
            if (div_b_zero) begin
              // Saturated quotient, dividend passed through as remainder
              result_q <= '1;
              mr_q     <= opa;
            end else begin
              prod_q <= {{WIDTH{1'b0}}, opa};
            end
          end
        end
        S_MUL: begin
          prod_q <= mul_next;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_last) begin
            result_q <= mul_next[WIDTH-1:0];
            mr_q     <= mul_next[2*WIDTH-1:WIDTH];
          end
        end
        S_DIV: begin
          prod_q <= div_next;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_last) begin
            result_q <= div_next[WIDTH-1:0];
            mr_q     <= div_next[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.to_ACC      = alu_res;
  assign bus.zero        = (alu_res == '0);
  assign bus.to_MR       = mr_q;
  assign bus.carry       = carry_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed expectations.
// Latency: checks single-cycle ops same cycle, MPY/DIV completion at cycle 17.
// Backpressure: exercises start re-assertion while busy.
module tb_alu_seq;

  localparam logic [31:0] C_ADD  = 32'h1 << 9;
  localparam logic [31:0] C_SUB  = 32'h1 << 11;
  localparam logic [31:0] C_AND  = 32'h1 << 12;
  localparam logic [31:0] C_OR   = 32'h1 << 14;
  localparam logic [31:0] C_NOT  = 32'h1 << 15;
  localparam logic [31:0] C_SHR  = 32'h1 << 16;
  localparam logic [31:0] C_SHL  = 32'h1 << 17;
  localparam logic [31:0] C_PASS = 32'h1 << 18;
  localparam logic [31:0] C_MPY  = 32'h1 << 19;
  localparam logic [31:0] C_DIV  = 32'h1 << 20;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16), .ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b);
    bus.control_signal = c;
    bus.from_ACC       = a;
    bus.from_BR        = b;
  endtask

  // Start an op in cycle 0, then observe cycles 1..20.
  // Operands switch to a2/b2 after the start edge; optionally re-assert MPY while busy/done.
  task automatic run_op(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] a2, input logic [15:0] b2, input bit reassert,
                        output int busy_cnt, output int done_cyc, output int done_cnt,
                        output int overlap);
    busy_cnt = 0;
    done_cyc = -1;
    done_cnt = 0;
    overlap  = 0;
    drive(c, a, b);
    step();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      drive((reassert && cyc <= 17) ? C_MPY : 32'h0, a2, b2);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.busy && bus.done) overlap++;
      step();
    end
    drive(32'h0, a2, b2);
  endtask

  task automatic read_pass(input string tag, input logic [15:0] exp);
    bus.control_signal = C_PASS;
    #1;
    check(tag, {16'h0, bus.to_ACC}, {16'h0, exp});
    bus.control_signal = 32'h0;
  endtask

  int bc, dc, dn, ov;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(32'h0, 16'h0, 16'h0);
    step();
    step();
    check("rst_busy",  {31'h0, bus.busy},        32'h0);
    check("rst_done",  {31'h0, bus.done},        32'h0);
    check("rst_mr",    {16'h0, bus.to_MR},       32'h0);
    check("rst_carry", {31'h0, bus.carry},       32'h0);
    check("rst_dbz",   {31'h0, bus.div_by_zero}, 32'h0);
    check("rst_acc",   {16'h0, bus.to_ACC},      32'h0);
    check("rst_zero",  {31'h0, bus.zero},        32'h1);
    rst = 1'b0;
    step();

    // Single-cycle ops: result same cycle, carry after the edge
    drive(C_ADD, 16'h7FFF, 16'h0001); #1;
    check("add1_res",  {16'h0, bus.to_ACC}, 32'h8000);
    check("add1_zero", {31'h0, bus.zero},   32'h0);
    step();
    check("add1_carry", {31'h0, bus.carry}, 32'h0);

    drive(C_ADD, 16'hFFFF, 16'h0001); #1;
    check("add2_res",  {16'h0, bus.to_ACC}, 32'h0000);
    check("add2_zero", {31'h0, bus.zero},   32'h1);
    step();
    check("add2_carry", {31'h0, bus.carry}, 32'h1);

    drive(C_SUB, 16'h0003, 16'h0005); #1;
    check("sub_res", {16'h0, bus.to_ACC}, 32'hFFFE);
    step();
    check("sub_carry", {31'h0, bus.carry}, 32'h0);

    drive(C_AND, 16'hF0F0, 16'h3C3C); #1;
    check("and_res", {16'h0, bus.to_ACC}, 32'h3030);
    step();
    check("and_carry", {31'h0, bus.carry}, 32'h0);

    drive(C_OR | C_NOT, 16'hF0F0, 16'h0F01); #1;
    check("or_prio_res", {16'h0, bus.to_ACC}, 32'hFFF1);
    drive(C_NOT, 16'h00FF, 16'h0000); #1;
    check("not_res", {16'h0, bus.to_ACC}, 32'hFF00);

    drive(C_SHR, 16'h0003, 16'h0000); #1;
    check("shr_res", {16'h0, bus.to_ACC}, 32'h0001);
    step();
    check("shr_carry", {31'h0, bus.carry}, 32'h1);

    drive(C_SHL, 16'h8001, 16'h0000); #1;
    check("shl_res", {16'h0, bus.to_ACC}, 32'h0002);
    step();
    check("shl_carry", {31'h0, bus.carry}, 32'h1);

    // PASS outranks ADD: result_q shown, carry untouched (1+1 would clear it)
    drive(C_PASS | C_ADD, 16'h0001, 16'h0001); #1;
    check("pass_prio_res", {16'h0, bus.to_ACC}, 32'h0000);
    step();
    check("pass_prio_carry", {31'h0, bus.carry}, 32'h1);
    drive(32'h0, 16'h0, 16'h0);
    step();

    // MPY 0x1234 * 0x0010 = 0x0001_2340, operands scrambled during busy
    run_op(C_MPY, 16'h1234, 16'h0010, 16'hAAAA, 16'h5555, 1'b0, bc, dc, dn, ov);
    check("mpy_busy_cycles", bc, 16);
    check("mpy_done_cycle",  dc, 17);
    check("mpy_done_pulses", dn, 1);
    check("mpy_overlap",     ov, 0);
    check("mpy_hi", {16'h0, bus.to_MR}, 32'h0001);
    read_pass("mpy_lo", 16'h2340);
    check("mpy_carry_kept", {31'h0, bus.carry}, 32'h1);

    // Re-asserted MPY while busy/done is ignored: 0x00FF * 0x0101 = 0x0000_FFFF
    run_op(C_MPY, 16'h00FF, 16'h0101, 16'h00FF, 16'h0101, 1'b1, bc, dc, dn, ov);
    check("remp_busy_cycles", bc, 16);
    check("remp_done_cycle",  dc, 17);
    check("remp_done_pulses", dn, 1);
    check("remp_hi", {16'h0, bus.to_MR}, 32'h0000);
    read_pass("remp_lo", 16'hFFFF);

    // DIV by zero: immediate done, no busy
    run_op(C_DIV, 16'h0042, 16'h0000, 16'h0042, 16'h0000, 1'b0, bc, dc, dn, ov);
    check("dz_busy_cycles", bc, 0);
    check("dz_done_cycle",  dc, 1);
    check("dz_done_pulses", dn, 1);
    check("dz_flag", {31'h0, bus.div_by_zero}, 32'h1);
    check("dz_rem",  {16'h0, bus.to_MR}, 32'h0042);
    read_pass("dz_quo", 16'hFFFF);

    // MPY and DIV together: MPY wins, 3*5 = 15 (DIV would give 0 r 3)
    run_op(C_MPY | C_DIV, 16'h0003, 16'h0005, 16'h0003, 16'h0005, 1'b0, bc, dc, dn, ov);
    check("both_done_cycle", dc, 17);
    check("both_dbz_clear", {31'h0, bus.div_by_zero}, 32'h0);
    check("both_hi", {16'h0, bus.to_MR}, 32'h0000);
    read_pass("both_lo", 16'h000F);

    // DIV 1000 / 7 = 142 r 6
    run_op(C_DIV, 16'd1000, 16'd7, 16'hFFFF, 16'h0001, 1'b0, bc, dc, dn, ov);
    check("div_busy_cycles", bc, 16);
    check("div_done_cycle",  dc, 17);
    check("div_overlap",     ov, 0);
    check("div_rem", {16'h0, bus.to_MR}, 32'd6);
    read_pass("div_quo", 16'h008E);
    check("div_carry_kept", {31'h0, bus.carry}, 32'h1);

    // Reset during cycle 8 of an MPY
    drive(C_MPY, 16'h1234, 16'h0010);
    step();
    drive(32'h0, 16'h0, 16'h0);
    for (int i = 1; i < 8; i++) step();
    check("mid_busy_before", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_mid_done", {31'h0, bus.done}, 32'h0);
    check("rst_mid_mr",   {16'h0, bus.to_MR}, 32'h0);
    read_pass("rst_mid_pass", 16'h0000);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.done) dn++;
      step();
    end
    check("rst_mid_no_done", dn, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
